weight_fetch_ctrl: RTL and testbench

Sequencer for the conv-layer 3-channel weight ROM (synchronous read, 1-cycle latency, shared enable). On start, it walks NUM_FILTERS x KERNEL_SIZE consecutive ROM words from a programmable base address. It drives the ROM enable and all three channel addresses in lockstep. It tags each returned word with filter/tap indices and presents it to the MAC array under a valid/ready handshake, with full backpressure.

---
 rtl/weight_fetch_ctrl_if.sv | 37 +++
 rtl/weight_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_fetch_ctrl_if.sv
// Handshake and ROM-side bundle for the conv-layer weight fetch sequencer.
// The "master" modport is the sequencer; "slave" is the environment (start source, ROM, MAC array).
interface weight_fetch_ctrl_if #(
  parameter int ROM_ADDR_BITS = 16,
  parameter int KERNEL_SIZE   = 9,
  parameter int NUM_FILTERS   = 16
);
  localparam int TAP_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                     start;
  logic                     abort;
  logic [ROM_ADDR_BITS-1:0] base_addr;
  logic                     rom_en;
  logic [ROM_ADDR_BITS-1:0] rom_addr1;
  logic [ROM_ADDR_BITS-1:0] rom_addr2;
  logic [ROM_ADDR_BITS-1:0] rom_addr3;
  logic                     w_valid;
  logic                     w_ready;
  logic [TAP_W-1:0]         w_tap;
  logic [FILT_W-1:0]        w_filt;
  logic                     w_last;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, abort, base_addr, w_ready,
    output rom_en, rom_addr1, rom_addr2, rom_addr3,
           w_valid, w_tap, w_filt, w_last, busy, done
  );

  modport slave (
    output start, abort, base_addr, w_ready,
    input  rom_en, rom_addr1, rom_addr2, rom_addr3,
           w_valid, w_tap, w_filt, w_last, busy, done
  );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Walks NUM_FILTERS x KERNEL_SIZE weight ROM words from a base address and presents
// each returned triple, tagged with filter/tap, under valid/ready with full backpressure.
module weight_fetch_ctrl #(
  parameter int ROM_ADDR_BITS = 16,
  parameter int KERNEL_SIZE   = 9,
  parameter int NUM_FILTERS   = 16,
  parameter int TAP_W         = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
  parameter int FILT_W        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(KERNEL_SIZE - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILTERS - 1);

  state_t                   state_q, state_d;
  logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [TAP_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic [FILT_W-1:0]        filt_cnt_q, filt_cnt_d;
  logic                     w_valid_q, w_valid_d;
  logic [TAP_W-1:0]         w_tap_q, w_tap_d;
  logic [FILT_W-1:0]        w_filt_q, w_filt_d;
  logic                     w_last_q, w_last_d;
  logic                     issue;
  logic                     last_issue;
  logic                     handshake;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tap_cnt_d  = tap_cnt_q;
    filt_cnt_d = filt_cnt_q;
    w_valid_d  = w_valid_q;
    w_tap_d    = w_tap_q;
    w_filt_d   = w_filt_q;
    w_last_d   = w_last_q;
    issue      = 1'b0;
    last_issue = (tap_cnt_q == TAP_LAST) && (filt_cnt_q == FILT_LAST);
    handshake  = w_valid_q && bus.w_ready;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = S_FETCH;
          addr_d     = bus.base_addr;
          tap_cnt_d  = '0;
          filt_cnt_d = '0;
        end
      end
      S_FETCH: begin
        // A new read may only be issued when the presented triple is leaving or absent.
        issue = !bus.abort && (!w_valid_q || bus.w_ready);
        if (issue && last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (handshake && w_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The tags follow the ROM word: captured on issue, held otherwise.
    if (issue) begin
      addr_d    = addr_q + ROM_ADDR_BITS'(1);
      w_valid_d = 1'b1;
      w_tap_d   = tap_cnt_q;
      w_filt_d  = filt_cnt_q;
      w_last_d  = last_issue;
      if (tap_cnt_q == TAP_LAST) begin
        tap_cnt_d  = '0;
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end else begin
        tap_cnt_d  = tap_cnt_q + TAP_W'(1);
      end
    end else if (handshake) begin
      w_valid_d = 1'b0;
    end

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tap_cnt_q  <= '0;
      filt_cnt_q <= '0;
      w_valid_q  <= 1'b0;
      w_tap_q    <= '0;
      w_filt_q   <= '0;
      w_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tap_cnt_q  <= tap_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      w_valid_q  <= w_valid_d;
      w_tap_q    <= w_tap_d;
      w_filt_q   <= w_filt_d;
      w_last_q   <= w_last_d;
    end
  end

  assign bus.rom_en    = issue;
  assign bus.rom_addr1 = addr_q;
  assign bus.rom_addr2 = addr_q;
  assign bus.rom_addr3 = addr_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_tap     = w_tap_q;
  assign bus.w_filt    = w_filt_q;
  assign bus.w_last    = w_last_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: vector table, directed corner sequences and randomized passes
// checked against a transaction-level model (pass base, issued count, accepted count).
module tb_weight_fetch_ctrl;
  localparam int AW    = 16;
  localparam int K     = 9;
  localparam int NF    = 2;
  localparam int TOTAL = K * NF;
  localparam int TW    = $clog2(K);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_fetch_ctrl_if #(.ROM_ADDR_BITS(AW), .KERNEL_SIZE(K), .NUM_FILTERS(NF)) bus();

  weight_fetch_ctrl #(.ROM_ADDR_BITS(AW), .KERNEL_SIZE(K), .NUM_FILTERS(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read ROM with shared enable; content is a fixed function of address.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  logic [31:0] rom_q;
  always @(posedge clk) if (bus.rom_en) rom_q <= rom_word(bus.rom_addr1);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle, 1=pass running, 2=done cycle.
  int          m_phase, m_iss, m_hs, done_cnt, en_run, en_max;
  logic [AW-1:0] m_base, m_first_addr;
  logic        stall_prev, saw_zero;
  logic [TW-1:0] prev_tap;
  logic [31:0] prev_data;

  task automatic model_reset();
    m_phase = 0; m_iss = 0; m_hs = 0; stall_prev = 1'b0;
  endtask

  task automatic model_step();
    logic ev, ee, hs;
    logic [AW-1:0] ea;
    ev = (m_iss - m_hs) == 1;
    ee = (m_phase == 1) && !bus.abort && (m_iss < TOTAL) && (!ev || bus.w_ready);
    chk("busy", bus.busy, m_phase != 0);
    chk("done", bus.done, m_phase == 2);
    chk("w_valid", bus.w_valid, ev);
    chk("rom_en", bus.rom_en, ee);
    if (bus.rom_en) begin
      ea = m_base + AW'(m_iss);
      chk("rom_addr1", bus.rom_addr1, ea);
      chk("rom_addr2", bus.rom_addr2, ea);
      chk("rom_addr3", bus.rom_addr3, ea);
      if (ea == '0) saw_zero = 1'b1;
      if (m_iss == 0) m_first_addr = bus.rom_addr1;
    end
    if (ev && stall_prev) begin
      chk("stall_tap", bus.w_tap, prev_tap);
      chk("stall_data", rom_q, prev_data);
    end
    hs = ev && bus.w_ready && !bus.abort && (m_phase == 1);
    if (hs) begin
      chk("w_tap", bus.w_tap, m_hs % K);
      chk("w_filt", bus.w_filt, m_hs / K);
      chk("w_last", bus.w_last, m_hs == TOTAL - 1);
      chk("rom_data", rom_q, rom_word(m_base + AW'(m_hs)));
    end
    if (bus.done) done_cnt++;
    en_run = bus.rom_en ? en_run + 1 : 0;
    if (en_run > en_max) en_max = en_run;
    stall_prev = ev && !bus.w_ready && !bus.abort && (m_phase == 1);
    prev_tap   = bus.w_tap;
    prev_data  = rom_q;
    case (m_phase)
      0: if (bus.start && !bus.abort) begin
           m_phase = 1; m_base = bus.base_addr; m_iss = 0; m_hs = 0;
         end
      1: if (bus.abort) begin
           m_phase = 0; m_iss = 0; m_hs = 0;
         end else begin
           if (ee) m_iss++;
           if (hs) begin
             m_hs++;
             if (m_hs == TOTAL) m_phase = 2;
           end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic half(input logic st, input logic ab, input logic rdy, input logic [AW-1:0] ba);
    bus.start = st; bus.abort = ab; bus.w_ready = rdy; bus.base_addr = ba;
    @(negedge clk);
    model_step();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic st, input logic ab, input logic rdy, input logic [AW-1:0] ba);
    half(st, ab, rdy, ba);
    tick();
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready plus start noise.
  task automatic run_pass(input logic [AW-1:0] base, input int mode, input int abort_at,
                          input int restart_at, input logic [AW-1:0] rbase, output logic aborted);
    int n;
    logic rdy, ab, st, restarted;
    logic [AW-1:0] ba;
    aborted = 1'b0; restarted = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, base);
    n = 0;
    while (m_phase != 0 && n < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((n % 4) == 0) || ((n % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ab = (abort_at >= 0) && !aborted && (m_phase == 1) && (m_hs == abort_at)
           && ((m_iss - m_hs) == 1) && rdy;
      if (ab) aborted = 1'b1;
      st = 1'b0; ba = base;
      if (restart_at >= 0 && !restarted && m_hs == restart_at) begin
        st = 1'b1; ba = rbase; restarted = 1'b1;
      end
      if (mode == 2 && $urandom_range(0, 5) == 0) begin
        st = 1'b1; ba = AW'($urandom);
      end
      half(st, ab, rdy, ba);
      tick();
      n++;
    end
    chk("pass_terminates", m_phase, 0);
  endtask

  typedef struct {
    logic st, ab, rdy;
    logic [AW-1:0] ba;
    logic busy, en, vld, ca;
    logic [AW-1:0] addr;
    logic [TW-1:0] tap;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ab_flag;
    int d0;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0101, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0102, 4'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};

    done_cnt = 0; en_run = 0; en_max = 0; saw_zero = 1'b0; m_base = '0; m_first_addr = '0;
    prev_tap = '0; prev_data = '0;
    model_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.w_ready = 1'b0; bus.base_addr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_addr", bus.rom_addr1, 0);
    chk("rst_valid", bus.w_valid, 0);
    chk("rst_tags", {bus.w_tap, bus.w_filt, bus.w_last}, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      half(tbl[i].st, tbl[i].ab, tbl[i].rdy, tbl[i].ba);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_rom_en", i), bus.rom_en, tbl[i].en);
      chk($sformatf("tbl%0d_valid", i), bus.w_valid, tbl[i].vld);
      if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), bus.rom_addr1, tbl[i].addr);
      if (tbl[i].vld) chk($sformatf("tbl%0d_tap", i), bus.w_tap, tbl[i].tap);
      tick();
    end

    // Full-rate pass: 18 consecutive issues, single done.
    d0 = done_cnt; en_max = 0;
    run_pass(16'h0100, 0, -1, -1, '0, ab_flag);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("fullrate_en_run", en_max, TOTAL);
    chk("fullrate_done", done_cnt - d0, 1);
    chk("fullrate_hs", m_hs, TOTAL);

    // Backpressure pattern 1,0,0,1.
    d0 = done_cnt;
    run_pass(16'h0100, 1, -1, -1, '0, ab_flag);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_hs", m_hs, TOTAL);

    // Address wrap across 0xFFFF.
    d0 = done_cnt; saw_zero = 1'b0;
    run_pass(16'hFFFA, 0, -1, -1, '0, ab_flag);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_saw_zero", saw_zero, 1);
    chk("wrap_done", done_cnt - d0, 1);

    // start while busy is ignored.
    d0 = done_cnt;
    run_pass(16'h0500, 0, -1, 5, 16'h2000, ab_flag);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("restart_done", done_cnt - d0, 1);

    // abort at transfer 7, then a clean pass.
    d0 = done_cnt;
    run_pass(16'h0700, 0, 7, -1, '0, ab_flag);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("abort_taken", ab_flag, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    run_pass(16'h0300, 0, -1, -1, '0, ab_flag);
    chk("after_abort_first", m_first_addr, 16'h0300);
    chk("after_abort_done", done_cnt - d0, 1);

    // Asynchronous reset mid-FETCH.
    d0 = done_cnt;
    cyc(1'b1, 1'b0, 1'b1, 16'h1234);
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rom_en", bus.rom_en, 0);
    chk("arst_valid", bus.w_valid, 0);
    chk("arst_addr", bus.rom_addr1, 0);
    chk("arst_tags", {bus.w_tap, bus.w_filt, bus.w_last}, 0);
    chk("arst_done", bus.done, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("arst_no_done", done_cnt - d0, 0);
    run_pass(16'h0040, 0, -1, -1, '0, ab_flag);
    chk("arst_first_issue", m_first_addr, 16'h0040);

    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      int abort_at;
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TOTAL - 1)) : -1;
      d0 = done_cnt;
      run_pass(AW'($urandom), 2, abort_at, -1, '0, ab_flag);
      repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b1, AW'($urandom));
      chk("rand_done", done_cnt - d0, ab_flag ? 0 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
